// File: rtl/keccak_absorb_pack.sv
// Byte-stream packer with Keccak multi-rate padding, emitting big-endian-ordered 64-bit rate words.
// Optional ABSORB_BYTE_CNT_EN adds o_msg_bytes, a saturating count of message bytes.
module keccak_absorb_pack #(
  parameter int unsigned BW_DATA    = 64,
  parameter int unsigned RATE_BYTES = 168,
  parameter logic [7:0]  DSEP       = 8'h1F
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [7:0]         i_byte,
  input  logic               i_byte_vld,
  input  logic               i_byte_last,
  input  logic               i_byte_nul,
  output logic               o_byte_rdy,
  output logic [BW_DATA-1:0] o_data,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic               o_blk_last,
  output logic               o_msg_last
`ifdef ABSORB_BYTE_CNT_EN
  ,
  output logic [31:0]        o_msg_bytes
`endif
);

  localparam int unsigned NWORDS    = RATE_BYTES / 8;
  localparam logic [7:0]  LAST_WORD = 8'(NWORDS - 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic               run;
  logic [2:0]         byte_idx;
  logic [7:0]         word_idx;
  logic [55:0]        asm_buf;
  logic               pad_first;
  logic [BW_DATA-1:0] data_r;
  logic               vld_r;
  logic               blk_r;
  logic               msg_r;

  logic               out_free;
  logic               byte_acc;
  logic               byte_store;
  logic               word_full;
  logic               pad_load;
  logic               word_end;
  logic [BW_DATA-1:0] pad_word;

  assign out_free   = !vld_r || i_rdy;
  // run keeps o_byte_rdy low during reset and the first cycle after it
  assign o_byte_rdy = run && (state == S_FILL) && ((byte_idx != 3'd7) || out_free);
  assign byte_acc   = i_byte_vld && o_byte_rdy;
  assign byte_store = byte_acc && !i_byte_nul;
  assign word_full  = byte_store && (byte_idx == 3'd7);
  assign pad_load   = (state == S_PAD) && out_free;
  assign word_end   = (word_idx == LAST_WORD);

  always_comb begin
    pad_word = '0;
    if (pad_first) begin
      for (int k = 0; k < 7; k++) begin
        if (3'(k) < byte_idx) pad_word[BW_DATA-1-8*k -: 8] = asm_buf[55-8*k -: 8];
      end
      for (int k = 0; k < 8; k++) begin
        if (3'(k) == byte_idx) pad_word[BW_DATA-1-8*k -: 8] = DSEP;
      end
    end
    if (word_end) pad_word[7:0] = pad_word[7:0] | 8'h80;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_FILL;
      run       <= 1'b0;
      byte_idx  <= '0;
      word_idx  <= '0;
      asm_buf   <= '0;
      pad_first <= 1'b0;
    end else begin
      run <= 1'b1;
      for (int k = 0; k < 7; k++) begin
        if (byte_store && (byte_idx == 3'(k))) asm_buf[55-8*k -: 8] <= i_byte;
      end
      case (state)
        S_FILL: begin
          if (byte_store) begin
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) word_idx <= word_end ? 8'd0 : word_idx + 8'd1;
          end
          if (byte_acc && i_byte_last) begin
            state     <= S_PAD;
            pad_first <= 1'b1;
          end
        end
        S_PAD: begin
          if (out_free) begin
            pad_first <= 1'b0;
            if (word_end) state <= S_DONE;
            else          word_idx <= word_idx + 8'd1;
          end
        end
        S_DONE: begin
          if (vld_r && i_rdy) begin
            state    <= S_FILL;
            byte_idx <= '0;
            word_idx <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      data_r <= '0;
      vld_r  <= 1'b0;
      blk_r  <= 1'b0;
      msg_r  <= 1'b0;
    end else if (word_full) begin
      data_r <= {asm_buf, i_byte};
      vld_r  <= 1'b1;
      blk_r  <= word_end;
      msg_r  <= 1'b0;
    end else if (pad_load) begin
      data_r <= pad_word;
      vld_r  <= 1'b1;
      blk_r  <= word_end;
      msg_r  <= word_end;
    end else if (i_rdy) begin
      vld_r  <= 1'b0;
    end
  end

  assign o_data     = data_r;
  assign o_vld      = vld_r;
  assign o_blk_last = blk_r;
  assign o_msg_last = msg_r;

`ifdef ABSORB_BYTE_CNT_EN
  logic [31:0] byte_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      byte_cnt <= '0;
    end else if (vld_r && i_rdy && msg_r) begin
      byte_cnt <= '0;
    end else if (byte_store && (byte_cnt != 32'hFFFF_FFFF)) begin
      byte_cnt <= byte_cnt + 32'd1;
    end
  end

  assign o_msg_bytes = byte_cnt;
`endif

endmodule

// File: doc/keccak_absorb_pack.md
Name: keccak_absorb_pack

Overview:
- Upstream feeder for the Keccak lane loader.
- Accepts a byte stream (valid/ready), packs 8 bytes per 64-bit word and applies Keccak multi-rate padding: domain-separator byte, zero fill, 0x80 in the final byte of the rate block.
- Emits rate-block words over a valid/ready interface. The first byte of each word is placed in bits [63:56], the byte order the lane loader converts to little-endian lanes.
- Used for the SHAKE128/SHAKE256/SHA3 absorb phase.

Parameters:
- BW_DATA, 64, output word width; fixed at 64.
- RATE_BYTES, 168, rate in bytes; must be a multiple of 8. Values: 168 = SHAKE128, 136 = SHAKE256/SHA3-256, 72 = SHA3-512.
- DSEP, 8'h1F, domain-separator pad byte. Values: 8'h1F = SHAKE, 8'h06 = SHA3.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_byte  in  8  message byte.
- i_byte_vld  in  1  i_byte valid.
- i_byte_last  in  1  final beat of message; qualified by i_byte_vld.
- i_byte_nul  in  1  with i_byte_last: beat carries no byte, for empty messages or already-closed streams.
- o_byte_rdy  out  1  byte accepted when i_byte_vld & o_byte_rdy.
- o_data  out  64  packed word; byte k of word at [63-8k -: 8].
- o_vld  out  1  o_data valid.
- i_rdy  in  1  downstream ready; word transferred on o_vld & i_rdy.
- o_blk_last  out  1  qualifies o_vld: last word of a rate block.
- o_msg_last  out  1  qualifies o_vld: last word of the padded message.

Behaviour:
- Reset (async, i_rstn=0): o_vld=0, o_data=0, o_blk_last=0, o_msg_last=0, o_byte_rdy=0. Byte index, word index and state cleared. Reset mid-message discards all partial data; no word is emitted afterwards until new bytes arrive.
- Counters:
  - byte_idx 0..7 within word.
  - word_idx 0..RATE_BYTES/8-1 within block; wraps to 0 after the word with o_blk_last is loaded.
- States: S_FILL (reset target), S_PAD, S_DONE.
- S_FILL:
  - o_byte_rdy=1 when byte_idx<7, or when the output register is free this cycle (!o_vld | i_rdy).
  - Accepted byte is written to assembly slot byte_idx; byte_idx increments.
  - On the 8th byte, the word loads into the output register; o_vld rises the next cycle. Latency: 1 cycle from 8th accept.
  - Accepted beat with i_byte_last → S_PAD. With i_byte_nul=1, no byte is stored.
- S_PAD (o_byte_rdy=0):
  - Generates one word per cycle when the output register is free.
  - First pad word: bytes [0,byte_idx) are message bytes; byte byte_idx = DSEP; remaining bytes 0.
  - Each later word is 0.
  - The word with word_idx = RATE_BYTES/8-1 additionally ORs 8'h80 into byte 7 (o_data[7:0]). If DSEP lands in byte 7 of that word, the byte is DSEP|8'h80.
  - If the last message byte completed the block exactly (byte_idx=0, word_idx=0 after wrap), a full extra block is generated: DSEP at byte 0 of word 0, 0x80 at byte 7 of the final word.
  - The final block's last word carries o_blk_last=1 and o_msg_last=1 → S_DONE.
- S_DONE: when that word is accepted (o_vld & i_rdy), counters clear and the block returns to S_FILL in the next cycle.
- Output register:
  - o_data, o_vld, o_blk_last and o_msg_last hold stable while o_vld & !i_rdy.
  - o_vld clears after acceptance unless a new word is loaded in the same cycle; back-to-back throughput is 1 word/cycle.
- o_blk_last is asserted on every block boundary word, including intermediate blocks of long messages.
- i_byte_nul without i_byte_last: the beat is accepted and ignored.

Optional Feature:
- Macro ABSORB_BYTE_CNT_EN.
- Defined: adds port o_msg_bytes out 32.
  - Count of message bytes accepted in the current message; cleared at reset and when the o_msg_last word is accepted.
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Empty message: single beat i_byte_last=1, i_byte_nul=1 (RATE_BYTES=168, DSEP=1F), i_rdy=1 → 21 words.
  - Word0 = 64'h1F00000000000000.
  - Words 1-19 = 0.
  - Word20 = 64'h0000000000000080 with o_blk_last=o_msg_last=1.
- Message AA BB CC (last on CC) → word0 = 64'hAABBCC1F00000000; word20 = 64'h...80; o_vld one cycle after last accept.
- 167 bytes of 0x01 → 21 words; word20 = 64'h010101010101019F; single block.
- 168 bytes of 0x01 → 42 words.
  - Word20 has o_blk_last=1, o_msg_last=0.
  - Word21 = 64'h1F00000000000000.
  - Word41 = 64'h0000000000000080 with both flags set.
- Backpressure: i_rdy=0 for 5 cycles during streaming → o_data/o_vld stable; o_byte_rdy=0 once the next word's 8th byte is pending. Resume with no byte lost or duplicated.
- Reset asserted after 11 bytes, then message 5A (last) → single block with word0 = 64'h5A1F000000000000. No residue from the earlier bytes.
